// File: rtl/twowire_mem_ap.sv
// twowire_mem_ap: APB3 memory access port turning TAR/DRW accesses into single AHB-Lite transfers
// Optional sticky DRW error flag in CSW[12] when TWD_MEM_AP_STICKY_ERR_EN is defined.
module twowire_mem_ap #(
  parameter logic [31:0] IDR = 32'h00000001,
  parameter int W_PADDR = 8
) (
  input  logic               dck,
  input  logic               drst,
  input  logic               apb_psel,
  input  logic               apb_penable,
  input  logic               apb_pwrite,
  input  logic [W_PADDR-1:0] apb_paddr,
  input  logic [31:0]        apb_pwdata,
  output logic [31:0]        apb_prdata,
  output logic               apb_pready,
  output logic               apb_pslverr,
  output logic [31:0]        ahb_haddr,
  output logic [1:0]         ahb_htrans,
  output logic               ahb_hwrite,
  output logic [2:0]         ahb_hsize,
  output logic [31:0]        ahb_hwdata,
  input  logic [31:0]        ahb_hrdata,
  input  logic               ahb_hready,
  input  logic               ahb_hresp
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] idx;
  logic [1:0] csw_size;
  logic csw_inc;
  logic [31:0] tar_q;
  logic [31:0] rdata_q;
  logic resp_q;
  logic err_q;
  logic setup, access, misaligned, launch, busy;
  logic [31:0] csw_rd;
  logic unused_paddr;
  assign unused_paddr = ^apb_paddr[W_PADDR-1:2];
  assign idx = apb_paddr[1:0];
  assign setup = apb_psel & ~apb_penable;
  assign access = apb_psel & apb_penable;
  assign busy = state_q != IDLE;
  assign misaligned = (csw_size == 2'd3) | ((csw_size == 2'd1) & tar_q[0]) |
                      ((csw_size == 2'd2) & (tar_q[1:0] != 2'd0));
  assign launch = (state_q == IDLE) & setup & (idx == 2'd2) & ~misaligned & ~err_q;
  assign csw_rd = {19'd0, err_q, 3'd0, busy, 3'd0, csw_inc, 2'd0, csw_size};
  assign ahb_htrans = (state_q == ADDR) ? 2'b10 : 2'b00;
  always_ff @(posedge dck) begin
    if (drst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = launch ? ADDR : IDLE;
      ADDR: state_d = ahb_hready ? DATA : ADDR;
      DATA: state_d = ahb_hready ? DONE : DATA;
      default: state_d = IDLE;
    endcase
  end
  // A DRW access phase seen while IDLE is one that was refused at setup.
  always_comb begin
    apb_pready = 1'b0;
    apb_pslverr = 1'b0;
    apb_prdata = 32'd0;
    if (access) begin
      if (idx != 2'd2) begin
        apb_pready = 1'b1;
        apb_prdata = (idx == 2'd0) ? csw_rd : (idx == 2'd1) ? tar_q : IDR;
      end else if (state_q == IDLE) begin
        apb_pready = 1'b1;
        apb_pslverr = 1'b1;
      end else if (state_q == DONE) begin
        apb_pready = 1'b1;
        apb_pslverr = resp_q;
        apb_prdata = rdata_q;
      end
    end
  end
  always_ff @(posedge dck) begin
    if (drst) begin
      csw_size <= 2'd0;
      csw_inc <= 1'b0;
      tar_q <= 32'd0;
      rdata_q <= 32'd0;
      resp_q <= 1'b0;
      ahb_haddr <= 32'd0;
      ahb_hsize <= 3'd0;
      ahb_hwrite <= 1'b0;
      ahb_hwdata <= 32'd0;
    end else begin
      if (access & apb_pwrite & (idx == 2'd0)) begin
        csw_size <= apb_pwdata[1:0];
        csw_inc <= apb_pwdata[4];
      end
      if (access & apb_pwrite & (idx == 2'd1)) tar_q <= apb_pwdata;
      else if ((state_q == DONE) & ~resp_q & csw_inc) tar_q <= tar_q + (32'd1 << csw_size);
      if (launch) begin
        ahb_haddr <= tar_q;
        ahb_hsize <= {1'b0, csw_size};
        ahb_hwrite <= apb_pwrite;
        ahb_hwdata <= apb_pwdata;
      end
      if ((state_q == DATA) & ahb_hready) begin
        rdata_q <= ahb_hwrite ? 32'd0 : ahb_hrdata;
        resp_q <= ahb_hresp;
      end
    end
  end
`ifdef TWD_MEM_AP_STICKY_ERR_EN
  // Set wins over a simultaneous write-one-to-clear.
  always_ff @(posedge dck) begin
    if (drst) err_q <= 1'b0;
    else if (access & (idx == 2'd2) & ((state_q == IDLE) | ((state_q == DONE) & resp_q))) err_q <= 1'b1;
    else if (access & apb_pwrite & (idx == 2'd0) & apb_pwdata[12]) err_q <= 1'b0;
  end
`else
  assign err_q = 1'b0;
`endif
endmodule

// File: tb/tb_twowire_mem_ap.sv
// tb_twowire_mem_ap: directed scoreboard bench for twowire_mem_ap with a small AHB responder model
module tb_twowire_mem_ap;
  logic dck = 1'b0;
  logic drst = 1'b1;
  logic apb_psel = 1'b0, apb_penable = 1'b0, apb_pwrite = 1'b0;
  logic [7:0] apb_paddr = 8'd0;
  logic [31:0] apb_pwdata = 32'd0;
  logic [31:0] apb_prdata;
  logic apb_pready, apb_pslverr;
  logic [31:0] ahb_haddr, ahb_hwdata;
  logic [31:0] ahb_hrdata = 32'd0;
  logic [1:0] ahb_htrans;
  logic ahb_hwrite, ahb_hready, ahb_hresp;
  logic [2:0] ahb_hsize;
  int checks = 0, passed = 0;
  logic [32:0] expq[$];
  int wait_n = 0;
  logic err_en = 1'b0;
  logic dphase = 1'b0;
  int dcnt = 0;
  int ns_cnt = 0;
  int ns0;
  logic [31:0] ns_addr = 32'd0, dp_wdata = 32'd0;
  logic [2:0] ns_size = 3'd0;
  logic ns_write = 1'b0;

  twowire_mem_ap dut (
    .dck(dck), .drst(drst),
    .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
    .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_prdata(apb_prdata),
    .apb_pready(apb_pready), .apb_pslverr(apb_pslverr),
    .ahb_haddr(ahb_haddr), .ahb_htrans(ahb_htrans), .ahb_hwrite(ahb_hwrite),
    .ahb_hsize(ahb_hsize), .ahb_hwdata(ahb_hwdata), .ahb_hrdata(ahb_hrdata),
    .ahb_hready(ahb_hready), .ahb_hresp(ahb_hresp)
  );

  always #5 dck = ~dck;

  // AHB completer: wait_n stall cycles, then either OKAY or a two-cycle ERROR.
  assign ahb_hready = !dphase || (dcnt == wait_n + (err_en ? 1 : 0));
  assign ahb_hresp = dphase && err_en && (dcnt >= wait_n);
  always @(posedge dck) begin
    if (drst) begin
      dphase <= 1'b0;
      dcnt <= 0;
    end else begin
      if (ahb_htrans == 2'b10) begin
        ns_cnt <= ns_cnt + 1;
        ns_addr <= ahb_haddr;
        ns_size <= ahb_hsize;
        ns_write <= ahb_hwrite;
      end
      if (dphase && ahb_hready) begin
        dphase <= 1'b0;
        dp_wdata <= ahb_hwdata;
      end else if (dphase) dcnt <= dcnt + 1;
      if (ahb_htrans == 2'b10 && ahb_hready) begin
        dphase <= 1'b1;
        dcnt <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic apb(input string tag, input logic w, input logic [1:0] a, input logic [31:0] d,
                     input logic [32:0] exp, input int exp_ws);
    logic [32:0] e;
    int ws;
    expq.push_back(exp);
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = w; apb_paddr = {6'd0, a}; apb_pwdata = d;
    @(posedge dck); #1 apb_penable = 1'b1;
    ws = 0;
    @(negedge dck);
    while (!apb_pready && ws < 60) begin
      ws++;
      @(negedge dck);
    end
    e = expq.pop_front();
    chk({tag, "_ws"}, 64'(ws), 64'(exp_ws));
    chk({tag, "_err"}, {63'd0, apb_pslverr}, {63'd0, e[32]});
    if (!w) chk({tag, "_data"}, {32'd0, apb_prdata}, {32'd0, e[31:0]});
    @(posedge dck); #1 apb_psel = 1'b0; apb_penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge dck);
    #1 drst = 1'b0;
    @(negedge dck);
    chk("rst_htrans", {62'd0, ahb_htrans}, 64'd0);
    chk("rst_haddr_hwdata", {ahb_haddr, ahb_hwdata}, 64'd0);
    chk("rst_hwrite_hsize", {60'd0, ahb_hwrite, ahb_hsize}, 64'd0);
    chk("rst_apb", {31'd0, apb_pready, apb_pslverr, apb_prdata}, 64'd0);
    @(posedge dck); #1;
    apb("rst_csw", 1'b0, 2'd0, 32'd0, {1'b0, 32'h0}, 0);
    // word write with auto-increment
    apb("tar_wr", 1'b1, 2'd1, 32'h20000000, {1'b0, 32'h0}, 0);
    apb("csw_wr", 1'b1, 2'd0, 32'h12, {1'b0, 32'h0}, 0);
    ns0 = ns_cnt;
    apb("drw_wr", 1'b1, 2'd2, 32'hDEADBEEF, {1'b0, 32'h0}, 2);
    chk("wr_nonseq_cnt", 64'(ns_cnt - ns0), 64'd1);
    chk("wr_haddr", {32'd0, ns_addr}, 64'h20000000);
    chk("wr_hsize_hwrite", {60'd0, ns_size, ns_write}, {60'd0, 3'd2, 1'b1});
    chk("wr_hwdata", {32'd0, dp_wdata}, 64'hDEADBEEF);
    apb("tar_inc", 1'b0, 2'd1, 32'd0, {1'b0, 32'h20000004}, 0);
    // byte read with TAR wrap
    apb("csw_byte", 1'b1, 2'd0, 32'h10, {1'b0, 32'h0}, 0);
    apb("tar_ff", 1'b1, 2'd1, 32'hFFFFFFFF, {1'b0, 32'h0}, 0);
    ahb_hrdata = 32'h000000A5;
    apb("drw_rd_byte", 1'b0, 2'd2, 32'd0, {1'b0, 32'h000000A5}, 2);
    chk("rd_hsize_hwrite", {60'd0, ns_size, ns_write}, {60'd0, 3'd0, 1'b0});
    apb("tar_wrap", 1'b0, 2'd1, 32'd0, {1'b0, 32'h0}, 0);
    // data phase stalled five cycles
    apb("csw_word", 1'b1, 2'd0, 32'h12, {1'b0, 32'h0}, 0);
    apb("csw_rd", 1'b0, 2'd0, 32'd0, {1'b0, 32'h12}, 0);
    apb("tar_100", 1'b1, 2'd1, 32'h100, {1'b0, 32'h0}, 0);
    wait_n = 5;
    ahb_hrdata = 32'h12345678;
    apb("drw_rd_wait", 1'b0, 2'd2, 32'd0, {1'b0, 32'h12345678}, 7);
    wait_n = 0;
    // two-cycle AHB error leaves TAR alone
    err_en = 1'b1;
    apb("drw_err", 1'b1, 2'd2, 32'hCAFEF00D, {1'b1, 32'h0}, 3);
    err_en = 1'b0;
    apb("tar_no_inc", 1'b0, 2'd1, 32'd0, {1'b0, 32'h104}, 0);
`ifdef TWD_MEM_AP_STICKY_ERR_EN
    apb("csw_sticky", 1'b0, 2'd0, 32'd0, {1'b0, 32'h1012}, 0);
    ns0 = ns_cnt;
    apb("drw_blocked", 1'b0, 2'd2, 32'd0, {1'b1, 32'h0}, 0);
    chk("blocked_nonseq", 64'(ns_cnt - ns0), 64'd0);
    apb("csw_clr", 1'b1, 2'd0, 32'h1012, {1'b0, 32'h0}, 0);
    apb("csw_cleared", 1'b0, 2'd0, 32'd0, {1'b0, 32'h12}, 0);
`else
    apb("csw_no_sticky", 1'b0, 2'd0, 32'd0, {1'b0, 32'h12}, 0);
    ns0 = ns_cnt;
    apb("drw_after_err", 1'b0, 2'd2, 32'd0, {1'b0, 32'h12345678}, 2);
    chk("after_err_nonseq", 64'(ns_cnt - ns0), 64'd1);
`endif
    // misaligned word access
    apb("csw_nowrap", 1'b1, 2'd0, 32'h02, {1'b0, 32'h0}, 0);
    apb("tar_1002", 1'b1, 2'd1, 32'h1002, {1'b0, 32'h0}, 0);
    ns0 = ns_cnt;
    apb("drw_misalign", 1'b0, 2'd2, 32'd0, {1'b1, 32'h0}, 0);
    chk("misalign_nonseq", 64'(ns_cnt - ns0), 64'd0);
    // reset during the data phase
    apb("tar_2000", 1'b1, 2'd1, 32'h2000, {1'b0, 32'h0}, 0);
    wait_n = 10;
    apb_psel = 1'b1; apb_penable = 1'b0; apb_pwrite = 1'b0; apb_paddr = 8'd2;
    @(posedge dck); #1 apb_penable = 1'b1;
    @(posedge dck); #1;
    chk("mid_in_dphase", {63'd0, dphase}, 64'd1);
    drst = 1'b1; apb_psel = 1'b0; apb_penable = 1'b0;
    @(negedge dck);
    chk("mid_htrans_idle", {62'd0, ahb_htrans}, 64'd0);
    @(posedge dck); #1 drst = 1'b0;
    wait_n = 0;
    apb("mid_csw", 1'b0, 2'd0, 32'd0, {1'b0, 32'h0}, 0);
    apb("mid_tar", 1'b0, 2'd1, 32'd0, {1'b0, 32'h0}, 0);
    apb("mid_idr", 1'b0, 2'd3, 32'd0, {1'b0, 32'h00000001}, 0);
    apb("idr_wr", 1'b1, 2'd3, 32'hFFFFFFFF, {1'b0, 32'h0}, 0);
    apb("idr_ro", 1'b0, 2'd3, 32'd0, {1'b0, 32'h00000001}, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
